// File: rtl/ieee_adder_arbiter_pkg.sv
// Shared constants and helpers for the shared single-precision adder arbiter.
package ieee_adder_arbiter_pkg;

    localparam int NUM_W  = 32;   // IEEE754 single word
    localparam int EXP_W  = 8;    // exponent field
    localparam int SIG_W  = 23;   // stored significand field
    localparam int LANE_W = 32;   // operand lane per requester

    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
    localparam logic [NUM_W-1:0] QNAN    = 32'h7FC0_0000;

    // Leading-zero count of a 27-bit working significand (27 when all zero).
    function automatic logic [4:0] clz27(input logic [26:0] v);
        logic [4:0] n;
        n = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) begin
                n = 5'(26 - i);
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/ieee_adder.sv
// Combinational IEEE754 single-precision adder, round-to-nearest-even,
// overflow saturates to infinity, exact cancellation yields +0.
module ieee_adder
    import ieee_adder_arbiter_pkg::*;
(
    input  logic [NUM_W-1:0] a,
    input  logic [NUM_W-1:0] b,
    input  logic             sub,
    output logic [NUM_W-1:0] y
);
    logic             sa, sb, s_big, s_sml;
    logic [EXP_W-1:0] ea, eb, e_big, e_sml, e_big_eff, e_sml_eff, diff;
    logic [SIG_W-1:0] fa, fb, f_big, f_sml;
    logic [SIG_W:0]   m_big, m_sml, mant;
    logic             a_nan, b_nan, a_inf, b_inf, round_up;
    logic [49:0]      wide;
    logic [26:0]      aligned, big_ext, norm;
    logic [27:0]      sum;
    logic [4:0]       lz;
    logic [9:0]       lim, shamt, e_res, e_fin;
    logic [24:0]      rnd;

    // Unpack, align the smaller operand, add/subtract, normalise and round.
    always_comb begin
        sa    = a[31];
        sb    = b[31] ^ sub;
        ea    = a[30:23];
        eb    = b[30:23];
        fa    = a[22:0];
        fb    = b[22:0];
        a_nan = (ea == EXP_MAX) && (fa != 23'd0);
        b_nan = (eb == EXP_MAX) && (fb != 23'd0);
        a_inf = (ea == EXP_MAX) && (fa == 23'd0);
        b_inf = (eb == EXP_MAX) && (fb == 23'd0);
        shamt = 10'd0;
        // Larger magnitude goes first so the difference is never negative.
        if ({eb, fb} > {ea, fa}) begin
            s_big = sb; e_big = eb; f_big = fb;
            s_sml = sa; e_sml = ea; f_sml = fa;
        end else begin
            s_big = sa; e_big = ea; f_big = fa;
            s_sml = sb; e_sml = eb; f_sml = fb;
        end
        // Denormals use exponent 1 with no hidden bit.
        e_big_eff = (e_big == 8'd0) ? 8'd1 : e_big;
        e_sml_eff = (e_sml == 8'd0) ? 8'd1 : e_sml;
        m_big     = {(e_big != 8'd0), f_big};
        m_sml     = {(e_sml != 8'd0), f_sml};
        diff      = e_big_eff - e_sml_eff;
        wide      = {m_sml, 26'd0} >> diff;
        if (diff > 8'd49) begin
            aligned = {26'd0, |m_sml};
        end else begin
            aligned = {wide[49:24], |wide[23:0]};
        end
        big_ext = {m_big, 3'b000};
        if (s_big == s_sml) begin
            sum = {1'b0, big_ext} + {1'b0, aligned};
        end else begin
            sum = {1'b0, big_ext} - {1'b0, aligned};
        end
        lz  = clz27(sum[26:0]);
        lim = {2'b00, e_big_eff} - 10'd1;
        if (sum[27]) begin
            norm  = {sum[27:2], sum[1] | sum[0]};
            e_res = {2'b00, e_big_eff} + 10'd1;
        end else begin
            // Never shift below exponent 1: the remainder stays denormal.
            shamt = ({5'd0, lz} < lim) ? {5'd0, lz} : lim;
            norm  = sum[26:0] << shamt;
            e_res = {2'b00, e_big_eff} - shamt;
        end
        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        rnd      = {1'b0, norm[26:3]} + {24'd0, round_up};
        if (rnd[24]) begin
            mant  = rnd[24:1];
            e_fin = e_res + 10'd1;
        end else begin
            mant  = rnd[23:0];
            e_fin = e_res;
        end
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
            y = QNAN;
        end else if (a_inf) begin
            y = {sa, EXP_MAX, 23'd0};
        end else if (b_inf) begin
            y = {sb, EXP_MAX, 23'd0};
        end else if (sum == 28'd0) begin
            y = {s_big & s_sml, 31'd0};
        end else if (e_fin >= 10'd255) begin
            y = {s_big, EXP_MAX, 23'd0};
        end else if (!mant[23]) begin
            y = {s_big, 8'd0, mant[22:0]};
        end else begin
            y = {s_big, e_fin[7:0], mant[22:0]};
        end
    end

endmodule

// File: rtl/ieee_rr_arbiter.sv
// Round-robin arbiter: first requester at or above rr_ptr (wrapping) wins.
module ieee_rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]          req,
    input  logic [$clog2(NREQ)-1:0]  rr_ptr,
    input  logic                     enable,
    output logic [NREQ-1:0]          grant,
    output logic [$clog2(NREQ)-1:0]  grant_idx
);
    localparam int PW = $clog2(NREQ);

    logic found;
    int   j;

    // Search upward from rr_ptr modulo NREQ; no grant while disabled.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        j         = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end else begin
                j = j;
            end
            if (enable && !found && req[j]) begin
                grant[j]  = 1'b1;
                grant_idx = PW'(j);
                found     = 1'b1;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/ieee_adder_arbiter.sv
// Shares one combinational adder among NREQ requesters: round-robin input
// arbitration, operand stage S1, result stage S2, tagged results.
module ieee_adder_arbiter
    import ieee_adder_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*LANE_W-1:0] req_a,
    input  logic [NREQ*LANE_W-1:0] req_b,
    input  logic [NREQ-1:0]        req_sub,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [NUM_W-1:0]       res_data,
    output logic [IDW-1:0]         res_id,
    output logic                   busy
);
    localparam int PW = $clog2(NREQ);

    logic [PW-1:0]    rr_ptr;
    logic [NREQ-1:0]  grant;
    logic [PW-1:0]    grant_idx;
    logic             s2_free, s1_adv, s1_free, xfer;
    logic [NUM_W-1:0] s1_a, s1_b, s2_data, core_y;
    logic             s1_sub, v1, v2;
    logic [IDW-1:0]   s1_id, s2_id;

    assign s2_free = !v2 | res_ready;
    assign s1_adv  = v1 & s2_free;
    assign s1_free = !v1 | s1_adv;
    // A grant is only ever issued to an asserted req_valid, so any grant transfers.
    assign xfer      = |grant;
    assign req_ready = grant;

    ieee_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req       (req_valid),
        .rr_ptr    (rr_ptr),
        .enable    (s1_free),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    ieee_adder u_core (
        .a   (s1_a),
        .b   (s1_b),
        .sub (s1_sub),
        .y   (core_y)
    );

    // Pipeline registers and round-robin pointer; reset discards in-flight work.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr  <= '0;
            v1      <= 1'b0;
            v2      <= 1'b0;
            s1_a    <= '0;
            s1_b    <= '0;
            s1_sub  <= 1'b0;
            s1_id   <= '0;
            s2_data <= '0;
            s2_id   <= '0;
        end else begin
            if (xfer) begin
                s1_a   <= req_a[int'(grant_idx)*LANE_W +: LANE_W];
                s1_b   <= req_b[int'(grant_idx)*LANE_W +: LANE_W];
                s1_sub <= req_sub[grant_idx];
                s1_id  <= IDW'(grant_idx);
                v1     <= 1'b1;
                rr_ptr <= (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + PW'(1);
            end else if (s1_adv) begin
                v1 <= 1'b0;
            end else begin
                v1 <= v1;
            end
            if (s1_adv) begin
                s2_data <= core_y;
                s2_id   <= s1_id;
                v2      <= 1'b1;
            end else if (res_ready) begin
                v2 <= 1'b0;
            end else begin
                v2 <= v2;
            end
        end
    end

    assign res_valid = v2;
    assign res_data  = s2_data;
    assign res_id    = s2_id;
    assign busy      = v1 | v2;

endmodule

// File: doc/ieee_adder_arbiter.md
Name: ieee_adder_arbiter

Overview:
- Shares one combinational single-precision adder core (ieee_adder) between NREQ requesters.
- Round-robin arbitration at the input, 2-stage registered pipeline around the core, valid/ready handshake on both sides.
- Each result is tagged with the requester index that issued it.
- Sits between the neuron-update units and the single instantiated adder, so only one adder is paid for in area.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of the requester tag; must be at least ceil(log2(NREQ)).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester operation valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  NREQ*32  operand A; requester i occupies bits [32i+31:32i].
- req_b  in  NREQ*32  operand B; same packing as req_a.
- req_sub  in  NREQ  1 = A-B, 0 = A+B.
- res_valid  out  1  result valid.
- res_ready  in  1  downstream accept.
- res_data  out  32  IEEE754 single result from the core.
- res_id  out  IDW  index of the requester that issued the result.
- busy  out  1  any pipeline stage occupied.

Behaviour:
- Reset: all stage valids 0, rr_ptr = 0, req_ready = 0, res_valid = 0, res_data = 0, res_id = 0, busy = 0.
- Stages:
  - S1 registers: a, b, sub, id, v1.
  - S2 registers: data, id, v2.
  - The core is combinational between S1 and S2; S2 captures the core output.
- Advance rules, evaluated each cycle:
  - s2_free = !v2 | res_ready.
  - s1_adv = v1 & s2_free.
  - s1_free = !v1 | s1_adv.
- Arbitration (combinational):
  - When s1_free, grant the first i with req_valid[i] set, searching from rr_ptr upward modulo NREQ.
  - req_ready[grant] = 1; all other bits 0.
  - When !s1_free, req_ready = 0.
  - req_ready depends on req_valid, so requesters must not make req_valid depend on req_ready.
- Handshake:
  - A transfer occurs when req_valid[i] & req_ready[i].
  - Requesters hold a, b and sub stable while valid and not ready.
  - On a transfer, S1 loads that requester's operands, sets v1 = 1, and rr_ptr becomes (grant+1) mod NREQ.
  - rr_ptr is unchanged on cycles with no transfer.
- S1 drain: if s1_adv and no new transfer, v1 goes to 0.
- S2 load/drain:
  - On s1_adv, S2 loads the core result and id, and v2 = 1.
  - Else if res_ready, v2 goes to 0.
- Outputs: res_valid = v2; res_data and res_id are driven straight from the S2 registers.
  - Once res_valid is asserted, res_data and res_id stay stable until res_ready is seen.
- Latency and throughput:
  - Accept cycle t gives res_valid at t+2 when unstalled.
  - Sustained throughput is 1 result per cycle with res_ready held high.
- Full: with v1 = v2 = 1 and res_ready = 0, req_ready = 0 and no register changes.
- Simultaneous events: S2 draining and S1 advancing in the same cycle is legal; S2 is replaced without a bubble.
- Ordering: results leave in acceptance order; no reordering.
- Fairness: any requester holding valid is granted within NREQ accepted transfers.
- Numerics are fully those of the core, including saturation to infinity and an exact zero for equal-operand subtraction. This block never modifies data.
- Reset mid-operation: in-flight operations are discarded and no result is emitted for them.
- busy = v1 | v2.

Decomposition:
- Shared defines: the existing width macros (32-bit number, exponent and significand widths).
- The arbiter adds one constant, the lane width of 32.
- Sub-module ieee_rr_arbiter:
  - Parameter NREQ.
  - Inputs: req vector, rr_ptr, enable.
  - Outputs: one-hot grant and encoded grant index.
- The core ieee_adder is instantiated once, combinationally.

Test Plan:
- Single add: req 0 issues 0x3F800000 + 0x40000000 (1.0 + 2.0) with res_ready = 1. Expect res_valid exactly 2 cycles after accept, res_data = 0x40400000, res_id = 0.
- Subtract and cancel:
  - req 2 issues 0x40400000 - 0x3F800000; expect 0x40000000 with id 2.
  - Then 0x3F800000 - 0x3F800000; expect 0x00000000.
- Round-robin: all 4 requesters valid continuously. Expect grant order 0, 1, 2, 3, 0, ... and one result per cycle with ids in the same order.
- Backpressure: hold res_ready = 0 for 5 cycles during a stream.
  - req_ready drops after 2 accepts.
  - res_data and res_id stay stable.
  - No loss or duplication when released.
- Overflow: 0x7F7FFFFF + 0x7F7FFFFF. Expect 0x7F800000.
- Reset mid-flight: assert reset with v1 = v2 = 1. Next cycle res_valid = 0, busy = 0, rr_ptr = 0, and no stale result appears afterwards.
